// File: rtl/iq_packer.sv
// iq_packer: captures signed I/Q sample pairs, decimates them and packs them
// into 32-bit words with a one-cycle write strobe for the AXI2S sink.
module iq_packer #(
    parameter int SW = 12
) (
    input  logic                 Sclk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sync,
    input  logic                 mode,
    input  logic [7:0]           decim,
    input  logic signed [SW-1:0] din_i,
    input  logic signed [SW-1:0] din_q,
    input  logic                 din_valid,
    output logic [31:0]          Sout,
    output logic                 Ien,
    output logic [31:0]          wcnt,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        sync_q, sync_d;
    logic [7:0]  dcnt_q, dcnt_d;
    logic [7:0]  decim_q, decim_d;
    logic        mode_q, mode_d;
    logic        phase_q, phase_d;
    logic [15:0] hold_q, hold_d;
    logic [31:0] sout_q, sout_d;
    logic        ien_q, ien_d;
    logic [31:0] wcnt_q, wcnt_d;

    logic        sync_rise;
    logic        accept;
    logic        phase_cur;
    logic [7:0]  dcnt_cur;
    logic [15:0] i_ext, q_ext;
    logic [7:0]  i_top, q_top;

    // Only the first cycle of a sync level counts as a frame event.
    assign sync_rise = sync & ~sync_q;

    // Mode 0 keeps full sign-extended samples; mode 1 keeps the top byte.
    assign i_ext = 16'(din_i);
    assign q_ext = 16'(din_q);
    assign i_top = din_i[SW-1 -: 8];
    assign q_top = din_q[SW-1 -: 8];

    // Next-state, decimation, packing and word counting.
    always_comb begin
        state_d   = state_q;
        sync_d    = sync;
        dcnt_d    = dcnt_q;
        decim_d   = decim_q;
        mode_d    = mode_q;
        phase_d   = phase_q;
        hold_d    = hold_q;
        sout_d    = sout_q;
        ien_d     = 1'b0;
        wcnt_d    = wcnt_q;
        accept    = 1'b0;
        // A re-sync in RUN restarts the frame before this cycle's sample is judged.
        dcnt_cur  = sync_rise ? 8'd0 : dcnt_q;
        phase_cur = sync_rise ? 1'b0 : phase_q;

        case (state_q)
            IDLE: begin
                if (en) state_d = ARMED;
            end
            ARMED: begin
                if (sync_rise) begin
                    state_d = RUN;
                    decim_d = decim;
                    mode_d  = mode;
                    dcnt_d  = 8'd0;
                    phase_d = 1'b0;
                end
            end
            RUN: begin
                dcnt_d  = dcnt_cur;
                phase_d = phase_cur;
                if (din_valid && en) begin
                    accept = (dcnt_cur == 8'd0);
                    dcnt_d = (dcnt_cur == decim_q) ? 8'd0 : dcnt_cur + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            if (!mode_q) begin
                sout_d = {q_ext, i_ext};
                ien_d  = 1'b1;
            end else if (!phase_cur) begin
                hold_d  = {q_top, i_top};
                phase_d = 1'b1;
            end else begin
                sout_d  = {q_top, i_top, hold_q};
                ien_d   = 1'b1;
                phase_d = 1'b0;
            end
        end

        // Dropping enable wins over everything and discards any half word.
        if (!en) begin
            state_d = IDLE;
            dcnt_d  = 8'd0;
            phase_d = 1'b0;
        end

        if (ien_d) wcnt_d = wcnt_q + 32'd1;
        if (state_d == IDLE) wcnt_d = 32'd0;
    end

    // State and datapath registers.
    always_ff @(posedge Sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= 1'b0;
            dcnt_q  <= 8'd0;
            decim_q <= 8'd0;
            mode_q  <= 1'b0;
            phase_q <= 1'b0;
            hold_q  <= 16'd0;
            sout_q  <= 32'd0;
            ien_q   <= 1'b0;
            wcnt_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            dcnt_q  <= dcnt_d;
            decim_q <= decim_d;
            mode_q  <= mode_d;
            phase_q <= phase_d;
            hold_q  <= hold_d;
            sout_q  <= sout_d;
            ien_q   <= ien_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign Sout  = sout_q;
    assign Ien   = ien_q;
    assign wcnt  = wcnt_q;
    assign state = state_q;

endmodule

// File: tb/tb_iq_packer.sv
// tb_iq_packer: directed and randomized checks of iq_packer against a
// frame-level reference model (keep every (decim+1)-th valid sample, pack).
module tb_iq_packer;
    localparam int SW = 12;

    logic          Sclk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          sync;
    logic          mode;
    logic [7:0]    decim;
    logic [SW-1:0] din_i;
    logic [SW-1:0] din_q;
    logic          din_valid;
    logic [31:0]   Sout;
    logic          Ien;
    logic [31:0]   wcnt;
    logic [1:0]    state;

    int checks = 0;
    int errors = 0;
    logic [31:0] got[$];
    logic [31:0] expw[$];

    iq_packer #(.SW(SW)) dut (
        .Sclk(Sclk), .rst_n(rst_n), .en(en), .sync(sync), .mode(mode),
        .decim(decim), .din_i(din_i), .din_q(din_q), .din_valid(din_valid),
        .Sout(Sout), .Ien(Ien), .wcnt(wcnt), .state(state)
    );

    always #5 Sclk = ~Sclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance one clock, look just after the edge, and log any emitted word.
    task automatic tick();
        @(posedge Sclk);
        #1;
        if (Ien === 1'b1) got.push_back(Sout);
    endtask

    task automatic drive(input bit v, input int i, input int q);
        din_valid = v;
        din_i     = i[SW-1:0];
        din_q     = q[SW-1:0];
        tick();
    endtask

    task automatic start_frame(input bit m, input logic [7:0] d);
        en = 1'b1; sync = 1'b0; din_valid = 1'b0; mode = m; decim = d;
        tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("run_entry_state", 32'(state), 32'd2);
    endtask

    task automatic end_frame();
        en = 1'b0; din_valid = 1'b0; sync = 1'b0;
        tick();
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_wcnt", wcnt, 32'd0);
    endtask

    function automatic int sext16(input int raw);
        int v;
        v = raw & ((1 << SW) - 1);
        if (v >= (1 << (SW - 1))) v = v - (1 << SW);
        return v & 'hFFFF;
    endfunction

    function automatic int top8(input int raw);
        return ((raw & ((1 << SW) - 1)) >> (SW - 8)) & 'hFF;
    endfunction

    function automatic logic [31:0] word0(input int i, input int q);
        logic [31:0] r;
        r = 32'(sext16(q));
        return (r << 16) | 32'(sext16(i));
    endfunction

    function automatic logic [31:0] word1(input int i0, input int q0, input int i1, input int q1);
        logic [31:0] r;
        r = 32'(top8(q1));
        r = (r << 8) | 32'(top8(i1));
        r = (r << 8) | 32'(top8(q0));
        r = (r << 8) | 32'(top8(i0));
        return r;
    endfunction

    initial begin
        int m, d, n, idx, hi, hq, si, sq;
        bit have, prev, s, v;

        rst_n = 1'b1; en = 1'b0; sync = 1'b0; mode = 1'b0; decim = 8'd0;
        din_i = '0; din_q = '0; din_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_sout", Sout, 32'd0);
        chk("reset_ien", 32'(Ien), 32'd0);
        chk("reset_wcnt", wcnt, 32'd0);
        tick(); tick();
        #2 rst_n = 1'b1;

        // Mode 0, full rate, latency-1 strobes and sign extension.
        start_frame(1'b0, 8'd0);
        drive(1'b1, 'h7FF, 'h001);
        chk("m0_ien0", 32'(Ien), 32'd1);
        chk("m0_sout0", Sout, 32'h0001_07FF);
        drive(1'b1, 'h800, 'hFFF);
        chk("m0_ien1", 32'(Ien), 32'd1);
        chk("m0_sout1", Sout, 32'hFFFF_F800);
        drive(1'b1, 1, 3);
        chk("m0_sout2", Sout, 32'h0003_0001);
        drive(1'b1, 2, 4);
        chk("m0_sout3", Sout, 32'h0004_0002);
        chk("m0_wcnt", wcnt, 32'd4);
        drive(1'b0, 0, 0);
        chk("m0_ien_idle", 32'(Ien), 32'd0);
        chk("m0_sout_hold", Sout, 32'h0004_0002);
        end_frame();

        // Mode 1 pair packing.
        start_frame(1'b1, 8'd0);
        drive(1'b1, 'h120, 'h340);
        chk("m1_first_noien", 32'(Ien), 32'd0);
        drive(1'b1, 'h560, 'h780);
        chk("m1_ien", 32'(Ien), 32'd1);
        chk("m1_sout", Sout, 32'h7856_3412);
        chk("m1_wcnt", wcnt, 32'd1);
        end_frame();

        // Decimation by 3 with a gap; decim change mid-RUN must be ignored.
        start_frame(1'b0, 8'd2);
        decim = 8'd0;
        got.delete();
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 16 + k, 32 + k);
            if (k == 1) drive(1'b0, 0, 0);
        end
        drive(1'b0, 0, 0);
        chk("dec_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("dec_w0", got[0], word0(16, 32));
            chk("dec_w1", got[1], word0(19, 35));
            chk("dec_w2", got[2], word0(22, 38));
        end
        chk("dec_wcnt", wcnt, 32'd3);
        end_frame();

        // Re-sync discards a held half word; a held-high sync counts once.
        start_frame(1'b1, 8'd0);
        drive(1'b1, 'hAB0, 'hCD0);
        sync = 1'b1;
        drive(1'b0, 0, 0);
        sync = 1'b0;
        drive(1'b1, 'h120, 'h340);
        chk("resync_a_noien", 32'(Ien), 32'd0);
        drive(1'b1, 'h560, 'h780);
        chk("resync_ien", 32'(Ien), 32'd1);
        chk("resync_sout", Sout, 32'h7856_3412);
        sync = 1'b1;
        drive(1'b1, 'h110, 'h220);
        chk("synclvl_a_noien", 32'(Ien), 32'd0);
        drive(1'b1, 'h330, 'h440);
        chk("synclvl_sout_ab", Sout, 32'h4433_2211);
        drive(1'b1, 'h550, 'h660);
        chk("synclvl_c_noien", 32'(Ien), 32'd0);
        sync = 1'b0;
        drive(1'b1, 'h770, 'h880);
        chk("synclvl_sout_cd", Sout, 32'h8877_6655);
        chk("synclvl_wcnt", wcnt, 32'd3);
        end_frame();

        // Enable drop right after an acceptance; valid input while ARMED.
        start_frame(1'b0, 8'd0);
        drive(1'b1, 5, 6);
        en = 1'b0;
        #1;
        chk("endrop_ien_fires", 32'(Ien), 32'd1);
        chk("endrop_sout", Sout, 32'h0006_0005);
        din_valid = 1'b1;
        tick();
        chk("endrop_state", 32'(state), 32'd0);
        chk("endrop_wcnt", wcnt, 32'd0);
        chk("endrop_no_ien", 32'(Ien), 32'd0);
        en = 1'b1; din_valid = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, k + 1, k + 2);
            chk("armed_no_ien", 32'(Ien), 32'd0);
            chk("armed_state", 32'(state), 32'd1);
        end
        end_frame();

        // Asynchronous reset mid-RUN with a half word held.
        start_frame(1'b1, 8'd0);
        drive(1'b1, 'h100, 'h200);
        drive(1'b1, 'h300, 'h400);
        drive(1'b1, 'hF00, 'hE00);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ien", 32'(Ien), 32'd0);
        chk("arst_sout", Sout, 32'd0);
        chk("arst_wcnt", wcnt, 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("arst_armed", 32'(state), 32'd1);
        drive(1'b1, 'h700, 'h700);
        chk("arst_nosync_noien", 32'(Ien), 32'd0);
        din_valid = 1'b0; mode = 1'b1; decim = 8'd0; sync = 1'b1;
        tick();
        sync = 1'b0;
        drive(1'b1, 'h120, 'h340);
        chk("arst_a_noien", 32'(Ien), 32'd0);
        drive(1'b1, 'h560, 'h780);
        chk("arst_resume_sout", Sout, 32'h7856_3412);
        chk("arst_resume_wcnt", wcnt, 32'd1);
        end_frame();

        // Randomized frames with gaps, random re-syncs and noisy mode/decim inputs.
        for (int f = 0; f < 25; f++) begin
            m = $urandom_range(1, 0);
            d = $urandom_range(4, 0);
            start_frame(m[0], d[7:0]);
            got.delete();
            expw.delete();
            idx = 0; have = 1'b0; prev = 1'b1; hi = 0; hq = 0;
            n = $urandom_range(40, 10);
            for (int k = 0; k < n; k++) begin
                s  = !prev && ($urandom_range(9, 0) == 0);
                v  = ($urandom_range(9, 0) < 7);
                si = $urandom_range((1 << SW) - 1, 0);
                sq = $urandom_range((1 << SW) - 1, 0);
                if (s) begin
                    idx  = 0;
                    have = 1'b0;
                end
                if (v) begin
                    if (idx % (d + 1) == 0) begin
                        if (m == 0) expw.push_back(word0(si, sq));
                        else if (!have) begin
                            have = 1'b1; hi = si; hq = sq;
                        end else begin
                            expw.push_back(word1(hi, hq, si, sq));
                            have = 1'b0;
                        end
                    end
                    idx++;
                end
                sync  = s;
                prev  = s;
                decim = 8'($urandom_range(255, 0));
                mode  = 1'($urandom_range(1, 0));
                drive(v, si, sq);
            end
            sync = 1'b0;
            drive(1'b0, 0, 0);
            chk("rnd_count", 32'(got.size()), 32'(expw.size()));
            for (int j = 0; j < got.size() && j < expw.size(); j++)
                chk("rnd_word", got[j], expw[j]);
            chk("rnd_wcnt", wcnt, 32'(expw.size()));
            end_frame();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
